ras_stack: RTL
==============

Name: ras_stack

Overview:
- Return address stack for the fetch-stage branch predictor.
- Sits beside the BTB/UPCT lookup. Fetch pushes the return target on a predicted call and pops on a predicted return.
- The top-of-stack value feeds the next-PC mux as the predicted return target.
- The stack pointer and count are checkpointed with each predicted branch, so a downstream mispredict can restore them.

Parameters:
RAS_ENTRIES, 8, number of stack entries (power of 2, >=2)
RAS_TARGET_WIDTH, 31, stored target width (PC[31:1])
LOG_RAS_ENTRIES, $clog2(RAS_ENTRIES), pointer width (derived)

Ports:
CLK  input  1  clock, all state updates on posedge
nRST  input  1  asynchronous active-low reset
push_valid  input  1  predicted call this cycle
push_target  input  RAS_TARGET_WIDTH  return address to push (PC+2/4, bits [31:1])
pop_valid  input  1  predicted return this cycle
ras_target_out  output  RAS_TARGET_WIDTH  current top-of-stack entry
ras_empty_out  output  1  count==0
ras_index_out  output  LOG_RAS_ENTRIES  current pointer, checkpointed by fetch
ras_count_out  output  LOG_RAS_ENTRIES+1  current valid count, checkpointed by fetch
restore_valid  input  1  mispredict restore from the backend
restore_index  input  LOG_RAS_ENTRIES  pointer to restore
restore_count  input  LOG_RAS_ENTRIES+1  count to restore (0..RAS_ENTRIES)

Behaviour:
State:
- stack[RAS_ENTRIES] of RAS_TARGET_WIDTH bits.
- ptr (LOG_RAS_ENTRIES bits), the index of the top entry.
- count (0..RAS_ENTRIES).

Reset:
- nRST low asynchronously clears every stack entry to 0, ptr to 0 and count to 0.
- During reset: ras_target_out=0, ras_empty_out=1, ras_index_out=0, ras_count_out=0.
- Reset mid-operation discards all entries; there is no partial state.

Outputs:
- All outputs are combinational from registered state: ras_target_out=stack[ptr], ras_index_out=ptr, ras_count_out=count.
- Outputs are valid in the same cycle fetch samples them. They reflect pre-update state; the new state is visible the cycle after the edge.

Per-cycle update, in priority order:
1. restore_valid=1:
   - ptr<=restore_index; count<=restore_count.
   - push_valid and pop_valid are ignored that cycle.
   - stack contents are untouched. Entries overwritten after the checkpoint are not recovered; this is an accepted prediction loss.
2. push_valid=1 and pop_valid=1 (return+call, e.g. jalr that both links and returns):
   - stack[ptr]<=push_target (top is replaced).
   - ptr unchanged.
   - count<=max(count,1).
3. push_valid only:
   - ptr<=ptr+1 modulo RAS_ENTRIES.
   - stack[ptr+1]<=push_target.
   - count<=min(count+1,RAS_ENTRIES).
4. pop_valid only:
   - ptr<=ptr-1 modulo RAS_ENTRIES.
   - count<=count-1, saturating at 0.
5. Neither: hold.

Boundaries:
- Full (count==RAS_ENTRIES) push: wraps and overwrites the oldest entry; count stays RAS_ENTRIES.
- Empty pop (count==0): ptr still decrements (wraps 0 -> RAS_ENTRIES-1) and count stays 0. ras_target_out shows stale data with ras_empty_out=1; fetch ignores the prediction when empty.
- Pointer wrap is plain modulo arithmetic on LOG_RAS_ENTRIES bits. No separate wrap bit; count carries fullness.
- restore_count > RAS_ENTRIES is illegal and is asserted against in simulation.

Timing:
- At most one push and one pop per cycle (one control-flow prediction per fetch block).
- No stalls, no handshake backpressure. The block always accepts.

Test Plan:
1. Reset then idle -> ras_empty_out=1, ras_index_out=0, ras_count_out=0, ras_target_out=0.
2. Push 0x100, 0x200, 0x300 on consecutive cycles -> ptr=3, count=3, target=0x300. Then pop once -> ptr=2, count=2, target=0x200.
3. Push 10 values 0x1..0xA from reset -> count saturates at 8, ptr=10 mod 8=2, target=0xA. Then 8 pops -> targets 0xA,0x9,...,0x3 and count reaches 0. A 9th pop -> ptr wraps, count stays 0, ras_empty_out=1.
4. Push 0x40, then same-cycle push 0x80 + pop -> ptr unchanged at 1, count=1, target=0x80. Repeat with count=0: push+pop 0x55 -> count=1, target=0x55, ptr unchanged.
5. Push 0x10, 0x20 (checkpoint index=2, count=2), push 0x30, pop, pop, then restore_valid with index=2/count=2 in the same cycle as push_valid 0x99 -> ptr=2, count=2, target=0x20, and 0x99 not written.
6. Assert nRST low asynchronously between clock edges with count=5 -> all outputs return to reset values immediately, before the next CLK edge. After release, push 0x7 -> ptr=1, count=1, target=0x7.

Source files
------------

// File: rtl/ras_stack.sv
// Return address stack for the fetch-stage predictor: push on predicted call, pop on
// predicted return, pointer/count restore from a mispredict checkpoint.
module ras_stack #(
  parameter int unsigned RAS_ENTRIES      = 8,
  parameter int unsigned RAS_TARGET_WIDTH = 31,
  parameter int unsigned LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES)
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  output logic [RAS_TARGET_WIDTH-1:0] ras_target_out,
  output logic                        ras_empty_out,
  output logic [LOG_RAS_ENTRIES-1:0]  ras_index_out,
  output logic [LOG_RAS_ENTRIES:0]    ras_count_out,
  input  logic                        restore_valid,
  input  logic [LOG_RAS_ENTRIES-1:0]  restore_index,
  input  logic [LOG_RAS_ENTRIES:0]    restore_count
);

  localparam int unsigned PW = LOG_RAS_ENTRIES;
  localparam int unsigned CW = LOG_RAS_ENTRIES + 1;
  localparam logic [CW-1:0] CountFull = CW'(RAS_ENTRIES);

  logic [RAS_TARGET_WIDTH-1:0] stack_q [RAS_ENTRIES];
  logic [PW-1:0]               ptr_q, ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        wr_en;
  logic [PW-1:0]               wr_addr;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = ptr_q;
    if (restore_valid) begin
      // Stack contents stay as-is; entries clobbered after the checkpoint are lost.
      ptr_d   = restore_index;
      count_d = restore_count;
    end else if (push_valid && pop_valid) begin
      wr_en = 1'b1;
      if (count_q == '0) begin
        count_d = CW'(1);
      end
    end else if (push_valid) begin
      ptr_d   = ptr_q + PW'(1);
      wr_en   = 1'b1;
      wr_addr = ptr_q + PW'(1);
      if (count_q != CountFull) begin
        count_d = count_q + CW'(1);
      end
    end else if (pop_valid) begin
      // Pointer moves even when empty; count alone tracks validity.
      ptr_d = ptr_q - PW'(1);
      if (count_q != '0) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        stack_q[i] <= '0;
      end
    end else if (wr_en) begin
      stack_q[wr_addr] <= push_target;
    end
  end

  assign ras_target_out = stack_q[ptr_q];
  assign ras_empty_out  = (count_q == '0);
  assign ras_index_out  = ptr_q;
  assign ras_count_out  = count_q;

  restore_count_legal: assert property (@(posedge CLK) disable iff (!nRST)
    restore_valid |-> (restore_count <= CountFull));

endmodule
